ras_ckpt_unit: RTL and testbench

- Parametrised return address stack (RAS) for the fetch-stage branch predictor.
- Circular stack of DEPTH return addresses.
- Speculative push/pop at fetch; in-order checkpoint FIFO of CKPT_N snapshots.
- Snapshots allow exact repair on an execute-stage mispredict, including the top entry clobbered by wrong-path pushes.

---
 rtl/ras_ckpt_unit.sv | 200 ++++++++++++++++++++
 tb/tb_ras_ckpt_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ras_ckpt_unit.sv
// ras_ckpt_unit: return address stack for the fetch-stage branch predictor.
// Circular stack of DEPTH return addresses with an in-order FIFO of CKPT_N
// snapshots. A snapshot restores top, count and the top entry, so wrong-path
// pushes that clobbered the top slot are undone on an execute-stage mispredict.
// Optional build macro: RAS_STATS_EN adds four 32-bit event counters read
// through dbg_sel/dbg_data. Without it, dbg_data is tied to zero.
//
// Checkpoint handshake: ckpt_req is a request that is never held off by
// back-pressure. ckpt_grant is high in the same cycle when the request is
// taken, and ckpt_tag then names the slot that was allocated. If ckpt_grant
// is low, nothing is allocated and the requester must not assume a snapshot
// exists.
module ras_ckpt_unit #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16,
  parameter int CKPT_N = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      lu_push,
  input  logic                      lu_pop,
  input  logic [ADDR_W-1:0]         lu_push_addr,
  output logic [ADDR_W-1:0]         pred_target,
  output logic                      pred_valid,
  input  logic                      ckpt_req,
  output logic                      ckpt_grant,
  output logic [$clog2(CKPT_N)-1:0] ckpt_tag,
  output logic                      ckpt_full,
  input  logic                      rs_valid,
  input  logic                      rs_mispred,
  input  logic [1:0]                dbg_sel,
  output logic [31:0]               dbg_data
);

  localparam int TW = $clog2(DEPTH);
  localparam int CW = $clog2(CKPT_N);

  // Stack storage and pointers
  logic [ADDR_W-1:0] stack_q [DEPTH];
  logic [TW-1:0]     top_q;
  logic [TW:0]       count_q;

  // Snapshot FIFO
  logic [TW-1:0]     snap_top   [CKPT_N];
  logic [TW:0]       snap_count [CKPT_N];
  logic [ADDR_W-1:0] snap_entry [CKPT_N];
  logic [CW-1:0]     head_q;
  logic [CW-1:0]     tail_q;
  logic [CW:0]       occ_q;

  logic fifo_empty;
  logic fifo_full;
  logic rec;
  logic rel;
  logic push_e;
  logic pop_e;
  logic grant;

  // Post-operation values for the stack
  logic [TW-1:0]     top_n;
  logic [TW:0]       count_n;
  logic [ADDR_W-1:0] entry_n;
  logic              wr_en;
  logic [TW-1:0]     wr_idx;
  logic              ovf_ev;
  logic              unf_ev;

  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == (CW+1)'(CKPT_N));
  // A mispredict repairs from the oldest snapshot; a correct resolve frees it.
  assign rec    = rs_valid & rs_mispred & ~fifo_empty;
  assign rel    = rs_valid & ~rs_mispred & ~fifo_empty;
  assign push_e = lu_push & ~stall & ~rec;
  assign pop_e  = lu_pop & ~stall & ~rec;
  // A same-cycle correct resolve frees a slot, so a full FIFO can still grant.
  assign grant  = ckpt_req & ~stall & ~rec & ~reset &
                  (~fifo_full | (rs_valid & ~rs_mispred));

  assign pred_target = stack_q[top_q];
  assign pred_valid  = (count_q != '0);
  assign ckpt_grant  = grant;
  assign ckpt_tag    = tail_q;
  assign ckpt_full   = fifo_full;

  // Compute the post-op top/count/top-entry and the single stack write
  always_comb begin
    top_n   = top_q;
    count_n = count_q;
    entry_n = stack_q[top_q];
    wr_en   = 1'b0;
    wr_idx  = top_q;
    ovf_ev  = 1'b0;
    unf_ev  = 1'b0;
    if (push_e && pop_e && (count_q != '0)) begin
      // Tail call: replace the top entry in place.
      wr_en   = 1'b1;
      entry_n = lu_push_addr;
    end else if (push_e) begin
      top_n   = top_q + 1'b1;
      wr_en   = 1'b1;
      wr_idx  = top_q + 1'b1;
      entry_n = lu_push_addr;
      if (count_q == (TW+1)'(DEPTH)) begin
        ovf_ev = 1'b1;
      end else begin
        count_n = count_q + 1'b1;
      end
    end else if (pop_e) begin
      if (count_q != '0) begin
        top_n   = top_q - 1'b1;
        count_n = count_q - 1'b1;
        entry_n = stack_q[top_q - 1'b1];
      end else begin
        unf_ev = 1'b1;
      end
    end
  end

  // Stack entries: repair write on recovery, otherwise the lookup-side write
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (rec) begin
        stack_q[snap_top[head_q]] <= snap_entry[head_q];
      end else if (wr_en) begin
        stack_q[wr_idx] <= lu_push_addr;
      end
    end
  end

  // Snapshot payload captured into the tail slot on grant
  always_ff @(posedge clk) begin
    if (!reset && grant) begin
      snap_top[tail_q]   <= top_n;
      snap_count[tail_q] <= count_n;
      snap_entry[tail_q] <= entry_n;
    end
  end

  // Pointers, count and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      top_q   <= '0;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
    end else if (rec) begin
      top_q   <= snap_top[head_q];
      count_q <= snap_count[head_q];
      head_q  <= tail_q;
      occ_q   <= '0;
    end else begin
      top_q   <= top_n;
      count_q <= count_n;
      if (grant) tail_q <= tail_q + 1'b1;
      if (rel)   head_q <= head_q + 1'b1;
      if (grant && !rel)      occ_q <= occ_q + 1'b1;
      else if (!grant && rel) occ_q <= occ_q - 1'b1;
    end
  end

`ifdef RAS_STATS_EN
  logic [31:0] cnt_push;
  logic [31:0] cnt_pop;
  logic [31:0] cnt_flow;
  logic [31:0] cnt_rec;

  // Event counters: effective pushes, real pops, over/underflows, recoveries
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_push <= '0;
      cnt_pop  <= '0;
      cnt_flow <= '0;
      cnt_rec  <= '0;
    end else begin
      if (push_e)                        cnt_push <= cnt_push + 1'b1;
      if (pop_e && (count_q != '0))      cnt_pop  <= cnt_pop + 1'b1;
      if (ovf_ev || unf_ev)              cnt_flow <= cnt_flow + 1'b1;
      if (rec)                           cnt_rec  <= cnt_rec + 1'b1;
    end
  end

  // Counter readback mux
  always_comb begin
    dbg_data = '0;
    case (dbg_sel)
      2'd0: dbg_data = cnt_push;
      2'd1: dbg_data = cnt_pop;
      2'd2: dbg_data = cnt_flow;
      default: dbg_data = cnt_rec;
    endcase
  end
`else
  assign dbg_data = '0;
  logic unused_stats;
  assign unused_stats = &{1'b0, dbg_sel, ovf_ev, unf_ev};
`endif

endmodule

// File: tb/tb_ras_ckpt_unit.sv
// tb_ras_ckpt_unit: directed bench for ras_ckpt_unit (DEPTH=16, CKPT_N=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled 2
// units after the edge, well away from it.
module tb_ras_ckpt_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        lu_push;
  logic        lu_pop;
  logic [31:0] lu_push_addr;
  logic [31:0] pred_target;
  logic        pred_valid;
  logic        ckpt_req;
  logic        ckpt_grant;
  logic [1:0]  ckpt_tag;
  logic        ckpt_full;
  logic        rs_valid;
  logic        rs_mispred;
  logic [1:0]  dbg_sel;
  logic [31:0] dbg_data;

  int total = 0;
  int bad   = 0;

`ifdef RAS_STATS_EN
  localparam logic [31:0] EXP_PUSH = 32'd3;
  localparam logic [31:0] EXP_POP  = 32'd0;
  localparam logic [31:0] EXP_FLOW = 32'd1;
  localparam logic [31:0] EXP_REC  = 32'd1;
`else
  localparam logic [31:0] EXP_PUSH = 32'd0;
  localparam logic [31:0] EXP_POP  = 32'd0;
  localparam logic [31:0] EXP_FLOW = 32'd0;
  localparam logic [31:0] EXP_REC  = 32'd0;
`endif

  ras_ckpt_unit #(.ADDR_W(32), .DEPTH(16), .CKPT_N(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .lu_push      (lu_push),
    .lu_pop       (lu_pop),
    .lu_push_addr (lu_push_addr),
    .pred_target  (pred_target),
    .pred_valid   (pred_valid),
    .ckpt_req     (ckpt_req),
    .ckpt_grant   (ckpt_grant),
    .ckpt_tag     (ckpt_tag),
    .ckpt_full    (ckpt_full),
    .rs_valid     (rs_valid),
    .rs_mispred   (rs_mispred),
    .dbg_sel      (dbg_sel),
    .dbg_data     (dbg_data)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall        = 1'b0;
    lu_push      = 1'b0;
    lu_pop       = 1'b0;
    lu_push_addr = '0;
    ckpt_req     = 1'b0;
    rs_valid     = 1'b0;
    rs_mispred   = 1'b0;
    dbg_sel      = 2'd0;
  endtask

  // Let combinational outputs settle after driving inputs
  task automatic settle();
    #1;
  endtask

  // One clock: edge, release inputs, settle
  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] a);
    lu_push = 1'b1;
    lu_push_addr = a;
    cyc();
  endtask

  task automatic pop();
    lu_pop = 1'b1;
    cyc();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #2;

    // Reset values
    do_reset();
    chk("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
    chk("rst_ckpt_full",  {31'd0, ckpt_full},  32'd0);
    chk("rst_ckpt_grant", {31'd0, ckpt_grant}, 32'd0);
    chk("rst_ckpt_tag",   {30'd0, ckpt_tag},   32'd0);
    chk("rst_dbg_data",   dbg_data,            32'd0);

    // Basic push/pop and underflow
    push(32'h100);
    push(32'h200);
    chk("pp_target_200", pred_target, 32'h200);
    chk("pp_valid_1",    {31'd0, pred_valid}, 32'd1);
    pop();
    chk("pp_target_100", pred_target, 32'h100);
    pop();
    chk("pp_valid_0", {31'd0, pred_valid}, 32'd0);
    pop();
    chk("pp_underflow_valid", {31'd0, pred_valid}, 32'd0);
    push(32'h55);
    chk("pp_after_unf_target", pred_target, 32'h55);
    pop();
    chk("pp_after_unf_empty", {31'd0, pred_valid}, 32'd0);

    // Overflow: 17 pushes, oldest entry lost
    for (int i = 0; i <= 16; i++) push(32'(i));
    chk("ovf_top", pred_target, 32'h10);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("ovf_pop_valid_%0d", k), {31'd0, pred_valid}, 32'd1);
      chk($sformatf("ovf_pop_target_%0d", k), pred_target, 32'(16 - k));
      pop();
    end
    chk("ovf_empty_after_16", {31'd0, pred_valid}, 32'd0);

    // Checkpoint and mispredict repair
    lu_push = 1'b1;
    lu_push_addr = 32'hA0;
    ckpt_req = 1'b1;
    settle();
    chk("rep_grant", {31'd0, ckpt_grant}, 32'd1);
    chk("rep_tag",   {30'd0, ckpt_tag},   32'd0);
    cyc();
    pop();
    push(32'hBB);
    chk("rep_wrong_path_top", pred_target, 32'hBB);
    rs_valid = 1'b1;
    rs_mispred = 1'b1;
    lu_push = 1'b1;
    lu_push_addr = 32'h77;
    ckpt_req = 1'b1;
    settle();
    chk("rep_grant_dropped", {31'd0, ckpt_grant}, 32'd0);
    cyc();
    chk("rep_target", pred_target, 32'hA0);
    chk("rep_valid",  {31'd0, pred_valid}, 32'd1);
    chk("rep_full",   {31'd0, ckpt_full},  32'd0);
    chk("rep_tail_kept", {30'd0, ckpt_tag}, 32'd1);
    pop();
    chk("rep_count_1", {31'd0, pred_valid}, 32'd0);

    // Fill the checkpoint FIFO
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill_full_before_%0d", i), {31'd0, ckpt_full}, 32'd0);
      ckpt_req = 1'b1;
      settle();
      chk($sformatf("fill_grant_%0d", i), {31'd0, ckpt_grant}, 32'd1);
      chk($sformatf("fill_tag_%0d", i),   {30'd0, ckpt_tag},   32'(i));
      cyc();
    end
    chk("fill_full", {31'd0, ckpt_full}, 32'd1);
    ckpt_req = 1'b1;
    settle();
    chk("fill_5th_denied", {31'd0, ckpt_grant}, 32'd0);
    rs_valid = 1'b1;
    settle();
    chk("fill_5th_grant_rel", {31'd0, ckpt_grant}, 32'd1);
    chk("fill_5th_tag",       {30'd0, ckpt_tag},   32'd0);
    cyc();
    chk("fill_still_full", {31'd0, ckpt_full}, 32'd1);
    rs_valid = 1'b1;
    cyc();
    chk("fill_release_not_full", {31'd0, ckpt_full}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      rs_valid = 1'b1;
      cyc();
    end

    // Tail call, stalled and unstalled
    push(32'h200);
    stall = 1'b1;
    lu_push = 1'b1;
    lu_pop = 1'b1;
    lu_push_addr = 32'h300;
    ckpt_req = 1'b1;
    settle();
    chk("tc_stall_grant", {31'd0, ckpt_grant}, 32'd0);
    cyc();
    chk("tc_stall_target", pred_target, 32'h200);
    lu_push = 1'b1;
    lu_pop = 1'b1;
    lu_push_addr = 32'h300;
    cyc();
    chk("tc_target", pred_target, 32'h300);
    pop();
    chk("tc_count_unchanged", {31'd0, pred_valid}, 32'd0);
    lu_push = 1'b1;
    lu_pop = 1'b1;
    lu_push_addr = 32'h400;
    cyc();
    chk("tc_empty_as_push_valid",  {31'd0, pred_valid}, 32'd1);
    chk("tc_empty_as_push_target", pred_target, 32'h400);
    pop();
    chk("tc_empty_again", {31'd0, pred_valid}, 32'd0);

    // Event counters
    do_reset();
    pop();
    lu_push = 1'b1;
    lu_push_addr = 32'h11;
    ckpt_req = 1'b1;
    cyc();
    push(32'h22);
    push(32'h33);
    rs_valid = 1'b1;
    rs_mispred = 1'b1;
    cyc();
    chk("st_rec_target", pred_target, 32'h11);
    dbg_sel = 2'd0; settle(); chk("st_push", dbg_data, EXP_PUSH);
    dbg_sel = 2'd1; settle(); chk("st_pop",  dbg_data, EXP_POP);
    dbg_sel = 2'd2; settle(); chk("st_flow", dbg_data, EXP_FLOW);
    dbg_sel = 2'd3; settle(); chk("st_rec",  dbg_data, EXP_REC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
